// File: rtl/timer_dev_pkg.sv
// rtl/timer_dev_pkg.sv - shared CPU constants: bridge map, timer offsets, states, modes
package timer_dev_pkg;

  // Bridge address map for the timer devices
  localparam logic [31:0] TIMER0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TIMER1_BASE = 32'h0000_7F10;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrlFields_t;

  function automatic logic [31:0] ctrlToWord(input ctrlFields_t c);
    return {28'd0, c};
  endfunction

endpackage

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - count-down timer with one-shot/auto-reload modes and maskable interrupt
module timer_dev
  import timer_dev_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  ctrlFields_t ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic [1:0]  state;
  logic [1:0]  nextState;
  logic        irqPend;
  logic        ctrlWr;
  logic        presetWr;
  logic        runEn;
  logic        reloadMode;

  assign ctrlWr     = sel & we & (addr == ADDR_CTRL);
  assign presetWr   = sel & we & (addr == ADDR_PRESET);
  assign reloadMode = (ctrl.mode == MODE_RELOAD);
  // A CTRL write clearing EN stops the FSM at this very edge; enabling waits for the register.
  assign runEn      = ctrl.en & ~(ctrlWr & ~wdata[0]);

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (runEn) nextState = ST_LOAD;
      ST_LOAD: nextState = ST_CNT;
      ST_CNT: begin
        if (!runEn)              nextState = ST_IDLE;
        else if (count <= 32'd1) nextState = ST_INT;
      end
      ST_INT:  nextState = (runEn && reloadMode) ? ST_LOAD : ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= 32'd0;
      preset  <= 32'd0;
      ctrl    <= '0;
      irqPend <= 1'b0;
    end else begin
      state <= nextState;

      if (state == ST_LOAD)
        count <= preset;
      else if (state == ST_CNT && runEn && count != 32'd0)
        count <= count - 32'd1;

      if (presetWr)
        preset <= wdata;

      // The written EN wins over the one-shot auto-clear.
      if (ctrlWr)
        ctrl <= ctrlFields_t'(wdata[3:0]);
      else if (state == ST_INT && !reloadMode)
        ctrl.en <= 1'b0;

      if (nextState == ST_INT && state != ST_INT)
        irqPend <= 1'b1;
      else if (ctrlWr || presetWr)
        irqPend <= 1'b0;
      else if (state == ST_INT && reloadMode)
        irqPend <= 1'b0;
    end
  end

  assign irq = ctrl.im & irqPend;

  always_comb begin
    rdata = 32'd0;
    case (addr)
      ADDR_CTRL:   rdata = ctrlToWord(ctrl);
      ADDR_PRESET: rdata = preset;
      ADDR_COUNT:  rdata = count;
      default:     rdata = 32'd0;
    endcase
  end

endmodule
